mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store unit between the MIPS core's data path and the byte-lane data memory port (`mem_addr`, `mem_data_in[0:3]`, `mem_data_out[0:3]`, `mem_write_en`).
- Accepts one byte, halfword or word access at a time over a valid/ready handshake.
- Performs aligned word reads and writes only; sub-word stores use read-modify-write.
- Sign- or zero-extends load data and returns it with a one-cycle response pulse.
- Flags misaligned or illegal requests without touching memory.

## Interface
- `MEM_LATENCY`, default 1 (legal 1..15): cycles `mem_addr` is held before `mem_data_out` is sampled.
- `clk`  input  1  clock; all state changes on rising edge.
- `rst_b`  input  1  reset, synchronous, active-high.
- `req_valid`  input  1  request present.
- `req_ready`  output  1  unit idle, can accept a request.
- `req_write`  input  1  1 = store, 0 = load.
- `req_size`  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_unsigned`  input  1  loads: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  input  32  byte address.
- `req_wdata`  input  32  store data; the low byte/half/word is used.
- `resp_valid`  output  1  one-cycle completion pulse.
- `resp_rdata`  output  32  extended load data; 0 for stores and errors.
- `resp_misaligned`  output  1  valid with `resp_valid`; request rejected.
- `mem_addr`  output  32  word-aligned memory address.
- `mem_data_in`  output  8×[0:3]  write bytes to memory.
- `mem_data_out`  input  8×[0:3]  read bytes from memory.
- `mem_write_en`  output  1  word write strobe.

## Operation
- Byte order is big-endian. Lane 0 holds the byte at `{addr[31:2],2'b00}`; the word value is `{lane0,lane1,lane2,lane3}`.
- The request is registered on accept (`req_valid & req_ready`). `req_*` inputs are ignored outside IDLE.
- **Misaligned rule:** a request is misaligned if it is a halfword with `addr[0]=1`, a word with `addr[1:0]≠0`, or has `req_size=11`.
- FSM states: IDLE, READ, WRITE, RESP.
- **IDLE**
  - `req_ready=1`.
  - On accept:
    - misaligned → RESP;
    - word store → WRITE;
    - otherwise → READ with the latency counter set to `MEM_LATENCY`.
- **READ**
  - Drives `mem_addr={addr[31:2],2'b00}`; the counter decrements each cycle.
  - On the last cycle (counter=1), `mem_data_out` is captured.
  - Then a load → RESP, a sub-word store → WRITE.
- **WRITE**
  - Drives `mem_addr` and `mem_write_en=1` for exactly one cycle, then → RESP.
  - `mem_data_in` source:
    - word store: `req_wdata` bytes;
    - sub-word store: the captured word with the selected lane(s) replaced by `wdata[7:0]` or `wdata[15:0]`.
- **RESP**
  - `resp_valid=1` for one cycle, then → IDLE.
  - `resp_rdata` is:
    - byte load: the lane at `addr[1:0]`, extended;
    - halfword load: lanes `addr[1]*2` and `+1`, extended;
    - word load: the word;
    - stores and errors: 0.
  - `resp_misaligned` is 1 only for a rejected request.
- Outside READ/WRITE: `mem_addr=0`, `mem_data_in` all 0, `mem_write_en=0`.

## Timing
- **Reset:** while `rst_b=1`, `mem_write_en` is forced 0 combinationally. At the edge the state becomes IDLE and the counter and captured registers clear. After reset:
  - `req_ready=1`;
  - `resp_valid=0`, `resp_rdata=0`, `resp_misaligned=0`;
  - `mem_addr=0`, `mem_data_in=0`, `mem_write_en=0`.
- **Reset mid-operation:** the in-flight access is dropped, with no response and no write. A half-completed RMW never writes.
- **Latency** (accept edge = cycle T):
  - misaligned: `resp_valid` in T+1;
  - word store: write in T+1, response in T+2;
  - load: READ in T+1..T+MEM_LATENCY, response in T+MEM_LATENCY+1;
  - sub-word store: write in T+MEM_LATENCY+1, response in T+MEM_LATENCY+2.
- **Throughput:** `req_ready` returns in the cycle after RESP. There is no back-to-back accept in the RESP cycle; the minimum issue interval is latency+1.
- `mem_addr` stays stable for all of READ and WRITE of one access.
- `req_valid` held high continuously is accepted once per IDLE visit.

## Test plan
Memory word 0x100 preloaded with `{0x81,0x22,0x33,0x44}`; tests run with `MEM_LATENCY=1` and `MEM_LATENCY=3`.
- **Word load:** `lw 0x100` → `resp_rdata=0x81223344`, `resp_misaligned=0`; response at T+MEM_LATENCY+1; `mem_write_en` never asserted.
- **Byte loads:** `lb 0x100` → `0xFFFFFF81`; `lbu 0x100` → `0x00000081`; `lb 0x103` → `0x00000044`.
- **Halfword loads:** `lhu 0x102` → `0x00003344`; `lh 0x100` → `0xFFFF8122`.
- **Sub-word stores (RMW):**
  - `sb 0x101`, wdata `0xDEADBEAB` → one `mem_write_en` pulse with `mem_data_in={81,AB,33,44}`; a following `lw` returns `0x81AB3344`.
  - `sh 0x102`, wdata `0x0000CAFE` → word `0x8122CAFE`.
- **Word store:** `sw 0x100`, wdata `0x01020304` → write in T+1 with lanes `{01,02,03,04}`, response at T+2.
- **Misaligned/illegal:** `lw 0x102`, `lh 0x101`, `req_size=11` → each gives `resp_valid` at T+1 with `resp_misaligned=1` and `resp_rdata=0`; `mem_addr` stays 0 and memory is unchanged.
- **Reset mid-RMW:** assert `rst_b` during READ of `sb 0x101` → no `mem_write_en` pulse, no response, `req_ready=1` the cycle after reset; memory still holds `0x81223344`.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit between the core data path and a byte-lane word memory
//
// Purpose:
//   Takes one byte, halfword or word access at a time from the core and
//   turns it into aligned word reads/writes on a big-endian byte-lane
//   memory port. Sub-word stores are done as read-modify-write. Load data
//   is sign- or zero-extended and returned with a one-cycle response pulse.
//   Misaligned or illegal requests are answered without touching memory.
//
// Ports:
//   clk, rst_b           clock; synchronous active-high reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_write            1 = store, 0 = load
//   req_size             00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned         loads: 1 = zero-extend, 0 = sign-extend
//   req_addr, req_wdata  byte address and store data (low bits used)
//   resp_valid           one-cycle completion pulse
//   resp_rdata           extended load data, 0 for stores and errors
//   resp_misaligned      request was rejected
//   mem_addr             word-aligned memory address
//   mem_data_in[0:3]     write lanes, lane 0 = most significant byte
//   mem_data_out[0:3]    read lanes, lane 0 = most significant byte
//   mem_write_en         word write strobe

module mem_access_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_data_in [0:3],
  input  logic [7:0]  mem_data_out [0:3],
  output logic        mem_write_en
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [3:0] LAT     = 4'(MEM_LATENCY);

  state_t      state;
  state_t      state_next;

  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_mis;
  logic [3:0]  cnt;
  logic [31:0] rword;

  logic        accept;
  logic        misaligned;
  logic        last_read;
  logic [7:0]  rd_lanes [0:3];
  logic [7:0]  wr_lanes [0:3];
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  assign accept    = req_valid && (state == S_IDLE);
  assign last_read = (cnt <= 4'd1);

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      SZ_HALF: misaligned = req_addr[0];
      SZ_WORD: misaligned = (req_addr[1:0] != 2'b00);
      SZ_BYTE: misaligned = 1'b0;
      default: misaligned = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (misaligned) begin
            state_next = S_RESP;
          end else if (req_write && (req_size == SZ_WORD)) begin
            state_next = S_WRITE;
          end else begin
            state_next = S_READ;
          end
        end
      end
      S_READ: begin
        if (last_read) begin
          state_next = r_write ? S_WRITE : S_RESP;
        end
      end
      S_WRITE: state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Request capture, latency counter and read-data capture
  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_write    <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_mis      <= 1'b0;
      cnt        <= 4'd0;
      rword      <= 32'd0;
    end else begin
      if (accept) begin
        r_write    <= req_write;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_mis      <= misaligned;
        cnt        <= LAT;
      end
      if (state == S_READ) begin
        cnt <= cnt - 4'd1;
        if (last_read) begin
          rword <= {mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]};
        end
      end
    end
  end

  // Captured word split into lanes; lane 0 is the most significant byte.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_lanes[i] = rword[31 - 8*i -: 8];
    end
  end

  // Write lanes: a word store uses the store data directly, a sub-word
  // store overlays the store data on the word read back in READ.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      wr_lanes[i] = rd_lanes[i];
    end
    case (r_size)
      SZ_WORD: begin
        for (int i = 0; i < 4; i++) begin
          wr_lanes[i] = r_wdata[31 - 8*i -: 8];
        end
      end
      SZ_HALF: begin
        wr_lanes[{r_addr[1], 1'b0}] = r_wdata[15:8];
        wr_lanes[{r_addr[1], 1'b1}] = r_wdata[7:0];
      end
      default: begin
        wr_lanes[r_addr[1:0]] = r_wdata[7:0];
      end
    endcase
  end

  assign byte_sel = rd_lanes[r_addr[1:0]];
  assign half_sel = {rd_lanes[{r_addr[1], 1'b0}], rd_lanes[{r_addr[1], 1'b1}]};

  // Outputs
  always_comb begin
    req_ready       = (state == S_IDLE);
    resp_valid      = (state == S_RESP);
    resp_misaligned = (state == S_RESP) && r_mis;
    resp_rdata      = 32'd0;
    mem_addr        = 32'd0;
    // Gated by reset so a half-finished read-modify-write can never write.
    mem_write_en    = (state == S_WRITE) && !rst_b;
    for (int i = 0; i < 4; i++) begin
      mem_data_in[i] = 8'd0;
    end

    if ((state == S_READ) || (state == S_WRITE)) begin
      mem_addr = {r_addr[31:2], 2'b00};
    end

    if (state == S_WRITE) begin
      for (int i = 0; i < 4; i++) begin
        mem_data_in[i] = wr_lanes[i];
      end
    end

    if ((state == S_RESP) && !r_write && !r_mis) begin
      case (r_size)
        SZ_BYTE: resp_rdata = {{24{byte_sel[7] & ~r_unsigned}}, byte_sel};
        SZ_HALF: resp_rdata = {{16{half_sel[15] & ~r_unsigned}}, half_sel};
        default: resp_rdata = rword;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit at MEM_LATENCY 1 and 3

module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b;
  logic        mem_init;
  logic [1:0]  vld;
  logic        wr;
  logic [1:0]  sz;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wd;

  logic [1:0]        rdy, rv, rmis, mwe;
  logic [1:0][31:0]  rdat, maddr, wl;
  logic [7:0]        mdi0 [0:3];
  logic [7:0]        mdi1 [0:3];
  logic [7:0]        mdo0 [0:3];
  logic [7:0]        mdo1 [0:3];
  logic [31:0]       mem0 [0:255];
  logic [31:0]       mem1 [0:255];

  int cyc = 0;
  int applied = 0;
  int miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  mem_access_unit #(.MEM_LATENCY(1)) u_lat1 (
    .clk(clk), .rst_b(rst_b), .req_valid(vld[0]), .req_ready(rdy[0]),
    .req_write(wr), .req_size(sz), .req_unsigned(uns), .req_addr(addr), .req_wdata(wd),
    .resp_valid(rv[0]), .resp_rdata(rdat[0]), .resp_misaligned(rmis[0]),
    .mem_addr(maddr[0]), .mem_data_in(mdi0), .mem_data_out(mdo0), .mem_write_en(mwe[0])
  );

  mem_access_unit #(.MEM_LATENCY(3)) u_lat3 (
    .clk(clk), .rst_b(rst_b), .req_valid(vld[1]), .req_ready(rdy[1]),
    .req_write(wr), .req_size(sz), .req_unsigned(uns), .req_addr(addr), .req_wdata(wd),
    .resp_valid(rv[1]), .resp_rdata(rdat[1]), .resp_misaligned(rmis[1]),
    .mem_addr(maddr[1]), .mem_data_in(mdi1), .mem_data_out(mdo1), .mem_write_en(mwe[1])
  );

  // Word memories; word 0x100 sits at index 0x40.
  assign wl[0] = {mdi0[0], mdi0[1], mdi0[2], mdi0[3]};
  assign wl[1] = {mdi1[0], mdi1[1], mdi1[2], mdi1[3]};
  for (genvar k = 0; k < 4; k++) begin : g_lanes
    assign mdo0[k] = mem0[maddr[0][9:2]][31 - 8*k -: 8];
    assign mdo1[k] = mem1[maddr[1][9:2]][31 - 8*k -: 8];
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= 32'd0;
        mem1[i] <= 32'd0;
      end
      mem0[64] <= 32'h81223344;
      mem1[64] <= 32'h81223344;
    end else begin
      if (mwe[0]) mem0[maddr[0][9:2]] <= wl[0];
      if (mwe[1]) mem1[maddr[1][9:2]] <= wl[1];
    end
  end

  typedef struct {
    int          inst;
    int          a;
    int          d;
    logic [31:0] rdata;
    logic        mis;
  } rexp_t;

  typedef struct {
    int          inst;
    int          a;
    int          d;
    logic [31:0] addr;
    logic [31:0] lanes;
  } wexp_t;

  rexp_t rq[$];
  wexp_t wq[$];
  rexp_t mr;
  wexp_t mw;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Monitor: every response and every write strobe must match the head of its queue.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rv[i]) begin
        applied++;
        if (rq.size() == 0 || rq[0].inst != i) begin
          miscompares++;
          $display("FAIL resp_unexpected inst%0d: rdata=%h mis=%b, required no response", i, rdat[i], rmis[i]);
        end else begin
          mr = rq.pop_front();
          if (rdat[i] !== mr.rdata || rmis[i] !== mr.mis || (cyc - mr.a + 1) != mr.d) begin
            miscompares++;
            $display("FAIL resp inst%0d: rdata=%h mis=%b at T+%0d, required rdata=%h mis=%b at T+%0d",
                     i, rdat[i], rmis[i], cyc - mr.a + 1, mr.rdata, mr.mis, mr.d);
          end
        end
      end
      if (mwe[i]) begin
        applied++;
        if (wq.size() == 0 || wq[0].inst != i) begin
          miscompares++;
          $display("FAIL write_unexpected inst%0d: addr=%h lanes=%h, required no write", i, maddr[i], wl[i]);
        end else begin
          mw = wq.pop_front();
          if (maddr[i] !== mw.addr || wl[i] !== mw.lanes || (cyc - mw.a + 1) != mw.d) begin
            miscompares++;
            $display("FAIL write inst%0d: addr=%h lanes=%h at T+%0d, required addr=%h lanes=%h at T+%0d",
                     i, maddr[i], wl[i], cyc - mw.a + 1, mw.addr, mw.lanes, mw.d);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    applied++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Issues one request; when track is set, pushes the expected response
  // (and write, if wdl > 0) and waits for the scoreboard to drain.
  task automatic issue(input int inst, input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] ad, input logic [31:0] d,
                       input int rd, input logic [31:0] erd, input logic emis,
                       input int wdl, input logic [31:0] el, input bit track);
    int n;
    int a;
    n = 0;
    @(negedge clk);
    wr = w; sz = s; uns = u; addr = ad; wd = d;
    vld[inst] = 1'b1;
    while (!rdy[inst] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", {31'd0, rdy[inst]}, 32'd1);
    a = cyc + 1;
    if (track) begin
      rq.push_back('{inst, a, rd, erd, emis});
      if (wdl > 0) wq.push_back('{inst, a, wdl, {ad[31:2], 2'b00}, el});
    end
    @(negedge clk);
    vld[inst] = 1'b0;
    if (track) begin
      n = 0;
      while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin
        @(negedge clk);
        n++;
      end
      applied++;
      if (rq.size() != 0 || wq.size() != 0) begin
        miscompares++;
        $display("FAIL drain_timeout inst%0d: %0d responses and %0d writes outstanding, required 0",
                 inst, rq.size(), wq.size());
        rq.delete();
        wq.delete();
      end
    end
  endtask

  task automatic load(input int inst, input logic [1:0] s, input logic u,
                      input logic [31:0] ad, input logic [31:0] erd);
    issue(inst, 1'b0, s, u, ad, 32'd0, lat_of(inst) + 1, erd, 1'b0, 0, 32'd0, 1'b1);
  endtask

  task automatic store(input int inst, input logic [1:0] s, input logic [31:0] ad,
                       input logic [31:0] d, input logic [31:0] el);
    if (s == 2'b10) issue(inst, 1'b1, s, 1'b0, ad, d, 2, 32'd0, 1'b0, 1, el, 1'b1);
    else issue(inst, 1'b1, s, 1'b0, ad, d, lat_of(inst) + 2, 32'd0, 1'b0, lat_of(inst) + 1, el, 1'b1);
  endtask

  task automatic bad(input int inst, input logic w, input logic [1:0] s, input logic [31:0] ad);
    issue(inst, w, s, 1'b0, ad, 32'hFFFF_FFFF, 1, 32'd0, 1'b1, 0, 32'd0, 1'b1);
  endtask

  initial begin
    rst_b = 1'b1; mem_init = 1'b1; vld = 2'b00;
    wr = 1'b0; sz = 2'b00; uns = 1'b0; addr = 32'd0; wd = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk("we_in_reset", {30'd0, mwe}, 32'd0);
    rst_b = 1'b0; mem_init = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_req_ready", {31'd0, rdy[i]}, 32'd1);
      chk("rst_resp_valid", {31'd0, rv[i]}, 32'd0);
      chk("rst_resp_rdata", rdat[i], 32'd0);
      chk("rst_resp_misaligned", {31'd0, rmis[i]}, 32'd0);
      chk("rst_mem_addr", maddr[i], 32'd0);
      chk("rst_mem_data_in", wl[i], 32'd0);
      chk("rst_mem_write_en", {31'd0, mwe[i]}, 32'd0);
    end

    for (int i = 0; i < 2; i++) begin
      load(i, 2'b10, 1'b0, 32'h100, 32'h81223344);
      load(i, 2'b00, 1'b0, 32'h100, 32'hFFFFFF81);
      load(i, 2'b00, 1'b1, 32'h100, 32'h00000081);
      load(i, 2'b00, 1'b0, 32'h103, 32'h00000044);
      load(i, 2'b01, 1'b1, 32'h102, 32'h00003344);
      load(i, 2'b01, 1'b0, 32'h100, 32'hFFFF8122);
      load(i, 2'b01, 1'b0, 32'h102, 32'h00003344);
      load(i, 2'b00, 1'b0, 32'h101, 32'h00000022);

      bad(i, 1'b0, 2'b10, 32'h102);
      bad(i, 1'b0, 2'b01, 32'h101);
      bad(i, 1'b0, 2'b11, 32'h100);
      bad(i, 1'b1, 2'b10, 32'h101);
      load(i, 2'b10, 1'b0, 32'h100, 32'h81223344);

      // Reset while the RMW of sb 0x101 is still reading.
      issue(i, 1'b1, 2'b00, 1'b0, 32'h101, 32'hDEADBEAB, 0, 32'd0, 1'b0, 0, 32'd0, 1'b0);
      rst_b = 1'b1;
      chk("we_during_rmw_reset", {31'd0, mwe[i]}, 32'd0);
      @(negedge clk);
      rst_b = 1'b0;
      chk("ready_after_reset", {31'd0, rdy[i]}, 32'd1);
      chk("resp_after_reset", {31'd0, rv[i]}, 32'd0);
      repeat (6) @(negedge clk);
      load(i, 2'b10, 1'b0, 32'h100, 32'h81223344);

      store(i, 2'b00, 32'h101, 32'hDEADBEAB, 32'h81AB3344);
      load(i, 2'b10, 1'b0, 32'h100, 32'h81AB3344);
      store(i, 2'b10, 32'h100, 32'h81223344, 32'h81223344);
      store(i, 2'b01, 32'h102, 32'h0000CAFE, 32'h8122CAFE);
      load(i, 2'b10, 1'b0, 32'h100, 32'h8122CAFE);
      store(i, 2'b10, 32'h100, 32'h01020304, 32'h01020304);
      load(i, 2'b10, 1'b0, 32'h100, 32'h01020304);
      load(i, 2'b00, 1'b0, 32'h103, 32'h00000004);
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

endmodule
